// File: rtl/set_cmd_loader.sv
// Byte-serial command front-end for the circle-set counting engine: assembles
// 5-byte frames, queues them, and launches each with a one-cycle en pulse.
module set_cmd_loader #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        set_busy,
  input  logic        set_valid,
  output logic        en,
  output logic [23:0] central,
  output logic [11:0] radius,
  output logic [1:0]  mode,
  output logic [2:0]  pending,
  output logic [7:0]  done_cnt
);

  // state | meaning
  // IDLE  | engine free; launch head of queue when pending and !set_busy
  // RUN   | command launched; wait for set_valid from the engine
  typedef enum logic {IDLE, RUN} state_t;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t          state, state_nxt;
  logic            launch;
  logic [2:0]      byte_cnt;
  logic [37:8]     asm_q;       // low byte of the command comes straight from in_data
  logic [37:0]     fifo_mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            accept, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Full check uses the registered occupancy only, so a same-cycle pop never frees a slot early.
  assign in_ready = (byte_cnt != 3'd4) || (pending < 3'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = accept && (byte_cnt == 3'd4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      asm_q    <= '0;
    end else if (accept) begin
      byte_cnt <= (byte_cnt == 3'd4) ? 3'd0 : byte_cnt + 3'd1;
      case (byte_cnt)
        3'd0:    asm_q[37:32] <= in_data[5:0];
        3'd1:    asm_q[31:24] <= in_data;
        3'd2:    asm_q[23:16] <= in_data;
        3'd3:    asm_q[15:8]  <= in_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {asm_q, in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      pending <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (launch) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, launch})
        2'b10:   pending <= pending + 3'd1;
        2'b01:   pending <= pending - 3'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      IDLE: if ((pending != 3'd0) && !set_busy) begin
        launch    = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (set_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are only written on a launch edge; the engine re-reads them every step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en      <= 1'b0;
      central <= '0;
      radius  <= '0;
      mode    <= '0;
    end else begin
      en <= launch;
      if (launch) {mode, radius, central} <= fifo_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            done_cnt <= '0;
    else if (set_valid) done_cnt <= done_cnt + 8'd1;
  end

endmodule

// File: tb/tb_set_cmd_loader.sv
// Directed, table-driven bench for set_cmd_loader (DEPTH=2) with hand-written
// sequences for queue-full back-pressure, busy blocking, resets and wrap.
module tb_set_cmd_loader;
  logic        clk = 1'b0;
  logic        rst, in_valid, set_busy, set_valid;
  logic [7:0]  in_data;
  logic        in_ready, en;
  logic [23:0] central;
  logic [11:0] radius;
  logic [1:0]  mode;
  logic [2:0]  pending;
  logic [7:0]  done_cnt;

  int errors = 0;
  int checks = 0;
  int exp_done = 0;

  set_cmd_loader #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .set_busy(set_busy), .set_valid(set_valid), .en(en), .central(central),
    .radius(radius), .mode(mode), .pending(pending), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] frame;
    logic [1:0]  m;
    logic [11:0] r;
    logic [23:0] c;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 0; i < 5; i++) send_byte(f[39-8*i -: 8]);
  endtask

  task automatic check_launch(input string name, input vec_t v, input logic [2:0] exp_pend);
    check({name, "_en"}, en, 1'b1);
    check({name, "_mode"}, mode, v.m);
    check({name, "_radius"}, radius, v.r);
    check({name, "_central"}, central, v.c);
    check({name, "_pending"}, pending, exp_pend);
  endtask

  task automatic end_run();
    set_valid = 1'b1;
    tick();
    set_valid = 1'b0;
    exp_done++;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_en"}, en, 1'b0);
    check({name, "_central"}, central, 24'h0);
    check({name, "_radius"}, radius, 12'h0);
    check({name, "_mode"}, mode, 2'h0);
    check({name, "_pending"}, pending, 3'h0);
    check({name, "_done_cnt"}, done_cnt, 8'h0);
    check({name, "_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    vecs[0] = '{40'h13_21_44_55_00, 2'd1, 12'h321, 24'h445500};
    vecs[1] = '{40'hE7_FF_01_02_03, 2'd2, 12'h7FF, 24'h010203};
    vecs[2] = '{40'h3F_00_FF_FF_FF, 2'd3, 12'hF00, 24'hFFFFFF};
    vecs[3] = '{40'hC0_A5_12_34_56, 2'd0, 12'h0A5, 24'h123456};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; set_busy = 1'b0; set_valid = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single frames through an idle engine
    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].frame);
      check("vec_pending_c1", pending, 3'd1);
      check("vec_en_c1", en, 1'b0);
      tick();
      check_launch("vec", vecs[i], 3'd0);
      tick();
      check("vec_en_single", en, 1'b0);
      end_run();
      check("vec_done_cnt", done_cnt, 8'(exp_done));
    end

    // Long run with queue fill and byte-4 back-pressure
    send_frame(vecs[0].frame);
    tick();
    check_launch("f1", vecs[0], 3'd0);
    set_busy = 1'b1;
    send_frame(vecs[1].frame);
    send_frame(vecs[2].frame);
    check("full_pending", pending, 3'd2);
    for (int i = 0; i < 4; i++) send_byte(vecs[3].frame[39-8*i -: 8]);
    in_valid = 1'b1;
    in_data  = 8'h56;
    for (int i = 0; i < 5; i++) begin
      check("full_in_ready", in_ready, 1'b0);
      check("f1_hold_central", central, 24'h445500);
      check("f1_no_en", en, 1'b0);
      tick();
    end
    set_busy = 1'b0; set_valid = 1'b1;
    tick();
    set_valid = 1'b0; exp_done++;
    check("sv_pending", pending, 3'd2);
    check("sv_in_ready", in_ready, 1'b0);
    check("sv_en", en, 1'b0);
    tick();
    check_launch("f2", vecs[1], 3'd1);
    check("pop_in_ready", in_ready, 1'b1);
    set_busy = 1'b1;
    tick();
    in_valid = 1'b0;
    check("refill_pending", pending, 3'd2);
    check("f2_en_low", en, 1'b0);
    repeat (3) tick();
    check("f2_hold_central", central, 24'h010203);
    set_busy = 1'b0; set_valid = 1'b1;
    tick();
    set_valid = 1'b0; exp_done++;
    check("f3_gap_en", en, 1'b0);
    tick();
    check_launch("f3", vecs[2], 3'd1);
    set_busy = 1'b1;
    repeat (3) tick();
    check("f3_hold_radius", radius, 12'hF00);
    set_busy = 1'b0; set_valid = 1'b1;
    tick();
    set_valid = 1'b0; exp_done++;
    tick();
    check_launch("f4", vecs[3], 3'd0);
    tick();
    end_run();

    // Stray set_valid while idle
    check("pre_stray_done", done_cnt, 8'(exp_done));
    end_run();
    check("stray_done", done_cnt, 8'(exp_done));
    check("stray_en", en, 1'b0);
    check("stray_central", central, 24'h123456);
    check("stray_in_ready", in_ready, 1'b1);

    // set_busy blocks launch in IDLE
    set_busy = 1'b1;
    send_frame(vecs[0].frame);
    for (int i = 0; i < 4; i++) begin
      check("busy_no_en", en, 1'b0);
      check("busy_pending", pending, 3'd1);
      tick();
    end
    set_busy = 1'b0;
    tick();
    check_launch("busy_release", vecs[0], 3'd0);
    tick();
    end_run();

    // Reset mid-frame after byte 2
    send_byte(8'hE7); send_byte(8'hFF); send_byte(8'h01);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_frame");
    tick();
    rst = 1'b0; exp_done = 0;
    send_frame(vecs[2].frame);
    tick();
    check_launch("after_rst_frame", vecs[2], 3'd0);
    tick();

    // Reset mid-RUN; FSM must be back in IDLE without a set_valid
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_run");
    tick();
    rst = 1'b0;
    send_frame(vecs[3].frame);
    tick();
    check_launch("after_rst_run", vecs[3], 3'd0);
    tick();
    end_run();

    // done_cnt wrap
    set_valid = 1'b1;
    repeat (255 - exp_done) tick();
    check("done_255", done_cnt, 8'd255);
    tick();
    set_valid = 1'b0;
    check("done_wrap", done_cnt, 8'd0);
    check("wrap_en", en, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
